// File: rtl/hyper_mem_responder.sv
// hyper_mem_responder: HyperBus memory target oversampled on sys_clk_i, serving
// memory and CR0/ID0 register accesses with configurable initial latency.
module hyper_mem_responder #(
  parameter int          MEM_WORDS  = 4096,
  parameter int          LATENCY_CK = 6,
  parameter bit          FIXED_2X   = 1'b1,
  parameter logic [15:0] ID0_VAL    = 16'h0C81
) (
  input  logic       sys_clk_i,
  input  logic       rst_i,
  input  logic       hyper_cs_ni,
  input  logic       hyper_ck_i,
  input  logic       hyper_reset_ni,
  input  logic [7:0] hyper_dq_i,
  input  logic       hyper_rwds_i,
  output logic [7:0] hyper_dq_o,
  output logic       hyper_dq_oe_o,
  output logic       hyper_rwds_o,
  output logic       hyper_rwds_oe_o,
  output logic       txn_done_o
);
  localparam int AW = $clog2(MEM_WORDS);
  // count of edges seen when the last latency edge (the one before the first data edge) arrives
  localparam logic [7:0] LAT_LAST = 8'(2 * LATENCY_CK * (FIXED_2X ? 2 : 1) + 1);
  localparam logic [15:0] CR0_RST = 16'h8F1F;
  localparam logic [11:0] SYNC_RST = 12'hC00;
  typedef enum logic [2:0] {IDLE, CA, LAT, WDATA, RDATA, WAIT_CS} state_t;
  logic [11:0] s1_q, s2_q;
  logic ck_p_q, cs_p_q;
  logic rstn_s, cs_s, ck_s, rwds_s, edge_w;
  logic [7:0] dq_s;
  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [47:0] ca_q, ca_d, ca_n;
  logic [31:0] wa;
  logic [AW-1:0] addr_q, addr_d, addr_nx;
  logic lo_q, lo_d, seen_q, seen_d, rd_load, we_hi, we_lo;
  logic [7:0] hb_q, hb_d, dq_q, dq_d;
  logic [15:0] cr0_q, cr0_d, rd_word;
  logic dq_oe_q, dq_oe_d, rwds_q, rwds_d, rwds_oe_q, rwds_oe_d, done_q, done_d;
  logic is_rd, is_reg, is_lin, reg_sel, unused_w;
  logic [7:0] mem_hi [MEM_WORDS];
  logic [7:0] mem_lo [MEM_WORDS];
  assign {rstn_s, cs_s, ck_s, rwds_s, dq_s} = s2_q;
  assign edge_w = ck_s ^ ck_p_q;
  assign {is_rd, is_reg, is_lin} = ca_q[47:45];
  assign reg_sel = ca_q[25];
  assign ca_n = {ca_q[39:0], dq_s};
  assign wa = {ca_n[44:16], ca_n[2:0]};
  assign addr_nx = is_lin ? addr_q + 1'b1 : {addr_q[AW-1:4], addr_q[3:0] + 4'd1};
  assign rd_word = is_reg ? (reg_sel ? cr0_q : ID0_VAL) : {mem_hi[addr_q], mem_lo[addr_q]};
  assign unused_w = ^{ca_q[44:40], wa[31:AW]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ca_d = ca_q;
    addr_d = addr_q;
    lo_d = lo_q;
    hb_d = hb_q;
    cr0_d = cr0_q;
    seen_d = seen_q;
    dq_d = dq_q;
    dq_oe_d = dq_oe_q;
    rwds_d = rwds_q;
    rwds_oe_d = rwds_oe_q;
    done_d = 1'b0;
    rd_load = 1'b0;
    we_hi = 1'b0;
    we_lo = 1'b0;
    if (!rstn_s) begin
      state_d = WAIT_CS;
      cr0_d = CR0_RST;
      seen_d = 1'b0;
      {dq_d, dq_oe_d, rwds_d, rwds_oe_d} = '0;
    end else if (cs_s && state_q != IDLE) begin
      state_d = IDLE;
      done_d = seen_q;
      seen_d = 1'b0;
      {dq_d, dq_oe_d, rwds_d, rwds_oe_d} = '0;
    end else begin
      case (state_q)
        IDLE: if (!cs_s && cs_p_q) begin
          state_d = CA;
          cnt_d = '0;
          lo_d = 1'b0;
          rwds_oe_d = 1'b1;
          rwds_d = FIXED_2X;
        end
        CA: if (edge_w) begin
          cnt_d = cnt_q + 8'd1;
          ca_d = ca_n;
          if (cnt_q == 8'd5) begin
            state_d = LAT;
            addr_d = wa[AW-1:0];
            rwds_oe_d = 1'b0;
            rwds_d = 1'b0;
          end
        end
        LAT: if (!is_rd && is_reg) state_d = WDATA;
        else if (edge_w) begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q == LAT_LAST) begin
            state_d = is_rd ? RDATA : WDATA;
            rd_load = is_rd;
          end
        end
        RDATA: if (edge_w) begin
          seen_d = 1'b1;
          rd_load = 1'b1;
        end
        WDATA: if (edge_w) begin
          seen_d = 1'b1;
          lo_d = !lo_q;
          hb_d = lo_q ? hb_q : dq_s;
          we_hi = !lo_q && !is_reg && !rwds_s;
          we_lo = lo_q && !is_reg && !rwds_s;
          addr_d = lo_q ? addr_nx : addr_q;
          cr0_d = (lo_q && is_reg && reg_sel) ? {hb_q, dq_s} : cr0_q;
        end
        WAIT_CS: state_d = WAIT_CS;
        default: state_d = IDLE;
      endcase
      // the byte loaded here is driven across the following data edge
      if (rd_load) begin
        dq_d = lo_q ? rd_word[7:0] : rd_word[15:8];
        rwds_d = !lo_q;
        dq_oe_d = 1'b1;
        rwds_oe_d = 1'b1;
        lo_d = !lo_q;
        addr_d = lo_q ? addr_nx : addr_q;
      end
    end
  end
  always_ff @(posedge sys_clk_i) begin
    if (rst_i) begin
      s1_q <= SYNC_RST;
      s2_q <= SYNC_RST;
      ck_p_q <= 1'b0;
      cs_p_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      ca_q <= '0;
      addr_q <= '0;
      lo_q <= 1'b0;
      hb_q <= '0;
      cr0_q <= CR0_RST;
      seen_q <= 1'b0;
      dq_q <= '0;
      dq_oe_q <= 1'b0;
      rwds_q <= 1'b0;
      rwds_oe_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      s1_q <= {hyper_reset_ni, hyper_cs_ni, hyper_ck_i, hyper_rwds_i, hyper_dq_i};
      s2_q <= s1_q;
      ck_p_q <= ck_s;
      cs_p_q <= cs_s;
      state_q <= state_d;
      cnt_q <= cnt_d;
      ca_q <= ca_d;
      addr_q <= addr_d;
      lo_q <= lo_d;
      hb_q <= hb_d;
      cr0_q <= cr0_d;
      seen_q <= seen_d;
      dq_q <= dq_d;
      dq_oe_q <= dq_oe_d;
      rwds_q <= rwds_d;
      rwds_oe_q <= rwds_oe_d;
      done_q <= done_d;
    end
  end
  always_ff @(posedge sys_clk_i) begin
    if (!rst_i && we_hi) mem_hi[addr_q] <= dq_s;
    if (!rst_i && we_lo) mem_lo[addr_q] <= dq_s;
  end
  assign hyper_dq_o = dq_q;
  assign hyper_dq_oe_o = dq_oe_q;
  assign hyper_rwds_o = rwds_q;
  assign hyper_rwds_oe_o = rwds_oe_q;
  assign txn_done_o = done_q;
endmodule

// File: doc/hyper_mem_responder.md
# hyper_mem_responder

HyperBus target (responder) model: the memory-device end of the HyperBus link driven by the udma HyperBus controller. It oversamples the bus on its own system clock, decodes the 48-bit command-address (CA), and serves memory or register reads and writes from an internal word array with configurable initial latency. It sits in the FPGA or emulation test harness on the pad side of the controller, in place of an external HyperRAM, and gives the verification environment a synthesizable, deterministic target.

## Interface
- MEM_WORDS, 4096: depth of the 16-bit memory array (power of two).
- LATENCY_CK, 6: initial latency in CK cycles.
- FIXED_2X, 1: 1 selects fixed double latency; RWDS is driven high during CA.
- ID0_VAL, 16'h0C81: value returned on an ID0 register read.
- sys_clk_i  in  1  system clock; must be at least 4x the HyperBus CK frequency.
- rst_i  in  1  synchronous, active-high reset.
- hyper_cs_ni  in  1  chip select, active low.
- hyper_ck_i  in  1  HyperBus clock (CK; CKn is not used).
- hyper_reset_ni  in  1  device reset, active low.
- hyper_dq_i  in  8  DQ from the controller.
- hyper_rwds_i  in  1  RWDS from the controller (write byte mask).
- hyper_dq_o  out  8  DQ read data.
- hyper_dq_oe_o  out  1  DQ output enable.
- hyper_rwds_o  out  1  RWDS: latency indicator or read strobe.
- hyper_rwds_oe_o  out  1  RWDS output enable.
- txn_done_o  out  1  one-cycle pulse when a transaction with at least one data byte ends.

## Operation
**Input sampling**
- cs_n, ck, dq, rwds and reset_n each pass through the same 2-flop synchronizer.
- Any change on synchronized ck is a CK edge; every CK edge carries one byte (DDR).

**CA capture**
- CA edges are numbered 1..6; byte 1 is CA[47:40].
- CA[47]: 1 = read, 0 = write.
- CA[46]: 1 = register space.
- CA[45]: 1 = linear burst, 0 = wrapped burst.
- Word address = {CA[44:16], CA[2:0]}, truncated to log2(MEM_WORDS) bits.

**FSM states:** IDLE, CA, LAT, WDATA, RDATA, WAIT_CS.
- IDLE -> CA: on synchronized cs_n falling.
- CA -> RDATA or WDATA: after edge 6, through LAT.
- Register write (CA[47]=0, CA[46]=1): zero latency. WDATA starts at edge 7.
- All other commands: first data byte is on edge 2*L+3, where L = LATENCY_CK*(FIXED_2X?2:1).
- Any state -> IDLE: on synchronized cs_n high. txn_done_o pulses if at least one data byte was transferred.

**During CA**
- hyper_rwds_oe_o=1 and hyper_rwds_o=FIXED_2X, from the cycle after cs_n falls until edge 6 is seen.
- RWDS is then released.

**Writes**
- Bytes are big-endian per word: the first byte goes to [15:8], the second to [7:0].
- A byte is written only if the sampled RWDS is 0 (RWDS is a mask).
- Memory writes commit per byte.

**Reads**
- On each data edge, drive the next byte on hyper_dq_o with hyper_dq_oe_o=1.
- hyper_rwds_o=1 for a high byte and 0 for a low byte; hyper_rwds_oe_o=1.

**Address advance** (after the low byte)
- Linear: +1, wrapping at MEM_WORDS.
- Wrapped: increment inside the aligned 16-word group.

**Registers**
- Word address bit 12 = 1 selects CR0; otherwise ID0.
- CR0 resets to 16'h8F1F, is read/write, and is stored only when both bytes are received.
- ID0 is read-only; writes to it are ignored. Reads beyond one word repeat the same register.

**hyper_reset_ni low:** abort to WAIT_CS, set CR0 = 16'h8F1F, release all outputs. Memory is kept.

## Timing
- Reset values: dq_o=0, dq_oe_o=0, rwds_o=0, rwds_oe_o=0, txn_done_o=0, state IDLE, CR0=16'h8F1F. The memory array is not reset.
- CK edge to sampled-byte action: 3 sys_clk cycles (2 synchronizer cycles plus 1 detect cycle).
- Read data is registered; outputs update 3 sys_clk cycles after the detected edge that precedes the data edge, so each byte is stable across its data edge.
- A read continues past the array end with wrap-around; it does not stall.
- If cs_n rises in the same cycle as a data edge, the cs_n rise wins and the byte is discarded.
- An odd trailing write byte (high byte only) is committed.
- Output enables drop in the cycle after cs_n is detected high.
- rst_i mid-transaction: return to IDLE next cycle with all outputs at reset values.

## Test plan
- Reset: assert rst_i for 2 cycles -> all outputs 0; a CR0 read returns 16'h8F1F; an ID0 read returns 16'h0C81.
- Linear write then read: write 4 words to word address 0x10 (data 16'h1122, 3344, 5566, 7788) with RWDS=0, L=12 -> reading 0x10..0x13 returns the same words; rwds_o toggles 1,0 per word; txn_done_o pulses twice.
- Byte mask: write 16'hAABB to 0x20 with RWDS=1 on the low byte, over prior 16'h0000 -> read returns 16'hAA00.
- Wrapped read: start at 0x1E with 4 words -> reads addresses 0x1E, 0x1F, 0x10, 0x11.
- Register write: zero-latency write of 16'h8E17 to CR0 -> data is taken at edges 7/8; a read returns 16'h8E17; a write to ID0 leaves ID0 unchanged.
- Abort: raise cs_n after CA edge 4 and, separately, pulse hyper_reset_ni mid-read -> outputs released within 1 cycle, no memory write, no txn_done_o, CR0 back to 16'h8F1F after the reset pulse.
